// File: rtl/div5_word_serializer.sv
// Parallel-to-serial framer feeding the divisible-by-5 FSM, MSB first.
// Optional back-to-back framing: DIV5_SER_BACK2BACK_EN.
module div5_word_serializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             last;
  logic             hs;

  assign busy        = (state == SHIFT);
  assign last        = busy && (cnt == '0);
  assign bit_valid   = busy;
  assign frame_start = busy && (cnt == LAST);
  assign frame_end   = last;
  assign bit_out     = busy && shreg[WIDTH-1];

  // in_ready is forced low for as long as reset is held
`ifdef DIV5_SER_BACK2BACK_EN
  assign in_ready = reset && ((state == IDLE) || last);
`else
  assign in_ready = reset && (state == IDLE);
`endif

  assign hs = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (hs) begin
          shreg_n = in_data;
          cnt_n   = LAST;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (last) begin
          if (hs) begin
            shreg_n = in_data;
            cnt_n   = LAST;
          end else begin
            state_n = IDLE;
          end
        end else begin
          shreg_n = {shreg[WIDTH-2:0], 1'b0};
          cnt_n   = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_div5_word_serializer.sv
// Directed bench for div5_word_serializer (WIDTH=8 and WIDTH=4 instances).
// Expected serial patterns are hand-derived from the words sent.
module tb_div5_word_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready, bit_out, bit_valid;
  logic       frame_start, frame_end, busy;

  logic [3:0] d4;
  logic       v4;
  logic       rdy4, bo4, bv4, fs4, fe4, busy4;

  int errors = 0;
  int checks = 0;

`ifdef DIV5_SER_BACK2BACK_EN
  localparam int GAP = 0;
`else
  localparam int GAP = 1;
`endif

  always #5 clk = ~clk;

  div5_word_serializer #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .bit_out(bit_out),
    .bit_valid(bit_valid), .frame_start(frame_start),
    .frame_end(frame_end), .busy(busy)
  );

  div5_word_serializer #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset),
    .in_data(d4), .in_valid(v4),
    .in_ready(rdy4), .bit_out(bo4),
    .bit_valid(bv4), .frame_start(fs4),
    .frame_end(fe4), .busy(busy4)
  );

  function automatic int res5(input logic [7:0] w);
    int r;
    r = 0;
    for (int i = 7; i >= 0; i--)
      r = (r * 2 + (w[i] ? 1 : 0)) % 5;
    return r;
  endfunction

  // Offer a word, wait for the handshake, then capture its 8 bits.
  task automatic xfer(input logic [7:0] w, input bit tog,
                      output logic [7:0] got, output logic [7:0] fsv,
                      output logic [7:0] fev, output logic [7:0] bvv);
    int n;
    got = '0; fsv = '0; fev = '0; bvv = '0;
    @(negedge clk);
    in_data  = w;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hs_timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      got    = {got[6:0], bit_out};
      fsv[i] = frame_start;
      fev[i] = frame_end;
      bvv[i] = bit_valid;
      if (tog) in_data = ~in_data;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
    v4 = 1'b0; d4 = 4'h0;
    #1 reset = 1'b0;
    #22;
    checks++;
    if ({bit_out, bit_valid, frame_start, frame_end, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outs: got=%b required 00000",
               {bit_out, bit_valid, frame_start, frame_end, busy});
    end
    checks++;
    if (in_ready !== 1'b0 || rdy4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got=%b%b required 00", in_ready, rdy4);
    end
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || rdy4 !== 1'b1) begin
      errors++;
      $display("FAIL release_ready: got=%b%b required 11", in_ready, rdy4);
    end
  endtask

  task automatic test_a5;
    logic [7:0] g, fs, fe, bv;
    xfer(8'hA5, 1'b0, g, fs, fe, bv);
    checks++;
    if (g !== 8'hA5) begin
      errors++; $display("FAIL a5_bits: got=%h required a5", g);
    end
    checks++;
    if (fs !== 8'h01 || fe !== 8'h80 || bv !== 8'hFF) begin
      errors++;
      $display("FAIL a5_flags: fs=%b fe=%b bv=%b required 00000001 10000000 11111111",
               fs, fe, bv);
    end
    checks++;
    if ((res5(g) == 0) !== 1'b1) begin
      errors++; $display("FAIL a5_verdict: res=%0d required 0", res5(g));
    end
    @(negedge clk);
    checks++;
    if (bit_valid !== 1'b0 || frame_end !== 1'b0) begin
      errors++;
      $display("FAIL a5_after: bv=%b fe=%b required 0 0", bit_valid, frame_end);
    end
  endtask

  task automatic test_back_to_back;
    logic [19:0] bo, bv, fs, fe;
    logic [7:0]  f1, f2;
    bit pend;
    int n, idx2;
    bo = '0; bv = '0; fs = '0; fe = '0; f1 = '0; f2 = '0;
    pend = 1'b0;
    @(negedge clk);
    in_data = 8'h0A; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_data = 8'h07;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      bo[i] = bit_out; bv[i] = bit_valid;
      fs[i] = frame_start; fe[i] = frame_end;
      if (pend) begin
        in_valid = 1'b0; pend = 1'b0;
      end else if (in_valid && in_ready) begin
        pend = 1'b1;
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) f1 = {f1[6:0], bo[i]};
    idx2 = -1;
    for (int i = 19; i > 0; i--) if (fs[i]) idx2 = i;
    checks++;
    if (f1 !== 8'h0A || fe[7] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: bits=%h fe7=%b required 0a 1", f1, fe[7]);
    end
    checks++;
    if (idx2 != 8 + GAP) begin
      errors++;
      $display("FAIL b2b_gap: second start=%0d required %0d", idx2, 8 + GAP);
    end
    if (idx2 > 0 && idx2 <= 12) begin
      for (int i = 0; i < 8; i++) f2 = {f2[6:0], bo[idx2+i]};
      checks++;
      if (f2 !== 8'h07 || fe[idx2+7] !== 1'b1 || bv[idx2+7] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_second: bits=%h fe=%b required 07 1", f2, fe[idx2+7]);
      end
    end
    checks++;
    if ((res5(f1) == 0) !== 1'b1 || (res5(f2) == 0) !== 1'b0) begin
      errors++;
      $display("FAIL b2b_verdict: res=%0d,%0d required 0,nonzero", res5(f1), res5(f2));
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] g, fs, fe, bv;
    int n, fe_seen;
    @(negedge clk);
    in_data = 8'hFF; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bit_valid !== 1'b1 || bit_out !== 1'b1) begin
      errors++;
      $display("FAIL mid_fourth: bv=%b bo=%b required 1 1", bit_valid, bit_out);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({bit_valid, frame_end, busy, in_ready} !== 4'b0) begin
      errors++;
      $display("FAIL mid_clear: got=%b required 0000",
               {bit_valid, frame_end, busy, in_ready});
    end
    fe_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (frame_end || bit_valid) fe_seen++;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (fe_seen != 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_release: stray=%0d ready=%b required 0 1", fe_seen, in_ready);
    end
    xfer(8'h05, 1'b0, g, fs, fe, bv);
    checks++;
    if (g !== 8'h05 || fs !== 8'h01 || fe !== 8'h80) begin
      errors++;
      $display("FAIL mid_next: bits=%h fs=%b fe=%b required 05 00000001 10000000",
               g, fs, fe);
    end
  endtask

  task automatic test_idle_hygiene;
    int hits;
    hits = 0;
    in_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      in_data = 8'($urandom);
      if (bit_valid) hits++;
    end
    checks++;
    if (hits != 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_quiet: bv_cycles=%0d ready=%b required 0 1", hits, in_ready);
    end
  endtask

  task automatic test_toggle;
    logic [7:0] g, fs, fe, bv;
    xfer(8'h3C, 1'b1, g, fs, fe, bv);
    checks++;
    if (g !== 8'h3C || fe !== 8'h80 || bv !== 8'hFF) begin
      errors++;
      $display("FAIL toggle_latch: bits=%h fe=%b bv=%b required 3c 10000000 11111111",
               g, fe, bv);
    end
  endtask

  task automatic test_width4;
    logic [3:0] g, fs, fe, bv;
    int n;
    g = '0; fs = '0; fe = '0; bv = '0;
    @(negedge clk);
    d4 = 4'hF; v4 = 1'b1;
    n = 0;
    while (!rdy4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    v4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      g = {g[2:0], bo4}; fs[i] = fs4; fe[i] = fe4; bv[i] = bv4;
    end
    checks++;
    if (g !== 4'hF || bv !== 4'hF) begin
      errors++; $display("FAIL w4_bits: bits=%h bv=%b required f 1111", g, bv);
    end
    checks++;
    if (fs !== 4'b0001 || fe !== 4'b1000) begin
      errors++;
      $display("FAIL w4_flags: fs=%b fe=%b required 0001 1000", fs, fe);
    end
    @(negedge clk);
    checks++;
    if (bv4 !== 1'b0) begin
      errors++; $display("FAIL w4_after: bv=%b required 0", bv4);
    end
  endtask

  initial begin
    test_reset();
    test_a5();
    test_back_to_back();
    test_reset_mid();
    test_idle_hygiene();
    test_toggle();
    test_width4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

endmodule
